sysreg_bank: RTL and testbench
==============================

# sysreg_bank

Parametrised system register bank: the CPU-visible control/status block for board-level signals, a 64-bit cycle counter with coherent reads, and edge-captured interrupt sources. It sits on the peripheral bus next to the other memory-mapped peripherals and drives LEDs, the SiI9024 reset line and one level interrupt to the CPU. Byte-enabled writes, write-1-to-clear status and a request/ready handshake that acknowledges each request exactly once.

## Interface
- FREQUENCY, 100000000: system clock frequency in Hz, returned by register FREQ.
- DEVICEID, 0: board identifier, returned by register DEVID.
- LED_WIDTH, 8: number of LED outputs, 1..32.
- NUM_IRQ, 4: number of interrupt inputs, 1..32.
- NUM_SCRATCH, 4: number of 32-bit scratch registers, 0..8.
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_request  in  1  bus request, held until o_ready is seen.
- i_rw  in  1  0 is read, 1 is write.
- i_address  in  4  word address.
- i_wdata  in  32  write data.
- i_wmask  in  4  byte enables for writes. Bit n enables i_wdata[8n+7:8n].
- o_rdata  out  32  read data, valid while o_ready=1.
- o_ready  out  1  one-cycle acknowledge.
- i_boot_mode_switch  in  1  sampled into boot_mode during reset.
- i_irq  in  NUM_IRQ  interrupt sources, synchronous to i_clock.
- o_leds  out  LED_WIDTH  LED drive.
- o_sil9024_reset  out  1  HDMI transmitter reset.
- o_irq  out  1  registered OR of (IRQ_STATUS & IRQ_ENABLE).

## Operation
- Register map (word address):
  - 0 CTRL, RW. Bit0 boot_mode, bit1 sil9024_reset.
  - 1 LEDS, RW. [LED_WIDTH-1:0].
  - 2 FREQ, RO.
  - 3 DEVID, RO.
  - 4 CYCLE_LO, RO.
  - 5 CYCLE_HI, RO.
  - 6 IRQ_STATUS, W1C.
  - 7 IRQ_ENABLE, RW.
  - 8..8+NUM_SCRATCH-1 SCRATCH, RW.
- Unmapped addresses, and addresses above the last scratch register, read as 0. Writes to them are ignored, but they are still acknowledged.
- Writes apply only to enabled bytes. Bits above a field's width read as 0. Writes to RO registers are ignored.
- Cycle counter:
  - 64 bits; increments every cycle not in reset; wraps from 2^64-1 to 0.
  - A read of CYCLE_LO returns the low word and, in the same cycle, latches the high word into a shadow register.
  - A read of CYCLE_HI returns the shadow.
  - Reading LO then HI is therefore coherent. Reading HI without a preceding LO returns the last shadow value (0 after reset).
- IRQ capture:
  - prev_irq is registered from i_irq. A rising edge (i_irq & ~prev_irq) sets the matching IRQ_STATUS bit.
  - prev_irq resets to 0, so an input that is high at reset release sets its status bit on the first cycle.
  - Writing 1 to a STATUS bit clears it. Writing 0 has no effect.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- Handshake FSM, states IDLE, ACK, RELEASE:
  - IDLE: on i_request=1, perform the access, register o_rdata, go to ACK.
  - ACK: o_ready=1 for exactly this cycle, then go to RELEASE.
  - RELEASE: wait for i_request=0, then go to IDLE. No new access is taken while in RELEASE.
- o_rdata keeps its last value outside ACK. Write accesses return 0 on o_rdata.

## Timing
- Reset values: o_ready=0, o_rdata=0, o_leds=0, o_sil9024_reset=0, o_irq=0. All other values:
  - boot_mode = i_boot_mode_switch
  - IRQ_STATUS = 0, IRQ_ENABLE = 0, scratch = 0
  - counter = 0, shadow = 0, FSM = IDLE
- Access latency: request sampled in cycle N, o_ready=1 in N+1. Write effects are visible from N+1.
- Minimum spacing between requests: request must be low for at least one cycle, so back-to-back acknowledges are at least 3 cycles apart.
- CYCLE_LO read returns the counter value of the sampling cycle N.
- o_irq is updated one cycle after the STATUS/ENABLE change that causes it.
- Reset mid-operation: the FSM goes to IDLE, o_ready drops in the same clock, and any pending access is dropped.

## Structure
- Package sysreg_pkg holds:
  - register address localparams (ADDR_CTRL .. ADDR_SCRATCH0)
  - the FSM enum typedef sysreg_state_t {IDLE, ACK, RELEASE}
  - the CTRL bit positions
- One sub-module, sysreg_irq_capture (parameter NUM_IRQ). It contains the edge detect, the STATUS/ENABLE registers with set-wins W1C, and the registered o_irq.
- The counter and the bus decode stay in the top module.

## Test plan
- Reset with i_boot_mode_switch=1, then read address 0 -> 0x00000001. Reads of FREQ and DEVID return the parameter values. o_leds=0.
- Write LEDS 0xDEADBEEF with i_wmask=4'b0001 -> o_leds=0xEF. Read back -> 0x000000EF. o_ready pulses exactly once while i_request is held 5 cycles.
- Counter wrap: preload the counter to 0x00000000_FFFFFFFF via force. Read LO -> 0xFFFFFFFF. Read HI 10 cycles later -> 0x00000000, even though the live counter is 0x00000001_xxxxxxxx.
- Set IRQ_ENABLE=0x1 and pulse i_irq[0] -> STATUS=0x1 and o_irq=1 one cycle after the status set. Write STATUS 0x1 -> o_irq=0. Write 0x1 to STATUS in the same cycle as a new i_irq[0] edge -> STATUS stays 0x1.
- Read address 15, and write 0xFFFFFFFF to FREQ -> read returns 0, FREQ is unchanged, both are acknowledged.
- Assert i_reset during the ACK state -> o_ready=0 the next cycle, and LEDS and scratch return to 0.

Source files
------------

// File: rtl/sysreg_pkg.sv
// Shared definitions for the system register bank: register map, CTRL bit layout,
// handshake FSM states and the byte-enable expansion helper.
package sysreg_pkg;

  localparam logic [3:0] ADDR_CTRL       = 4'd0;
  localparam logic [3:0] ADDR_LEDS       = 4'd1;
  localparam logic [3:0] ADDR_FREQ       = 4'd2;
  localparam logic [3:0] ADDR_DEVID      = 4'd3;
  localparam logic [3:0] ADDR_CYCLE_LO   = 4'd4;
  localparam logic [3:0] ADDR_CYCLE_HI   = 4'd5;
  localparam logic [3:0] ADDR_IRQ_STATUS = 4'd6;
  localparam logic [3:0] ADDR_IRQ_ENABLE = 4'd7;
  localparam logic [3:0] ADDR_SCRATCH0   = 4'd8;

  localparam int CTRL_BOOT_MODE     = 0;
  localparam int CTRL_SIL9024_RESET = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } sysreg_state_t;

  // Expand the 4-bit byte enable into a per-bit write mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] wmask);
    return {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  endfunction

endpackage

// File: rtl/sysreg_irq_capture.sv
// Edge-captured interrupt sources: rising-edge detect, W1C status with set priority,
// enable mask and a registered level interrupt out.
module sysreg_irq_capture #(
  parameter int NUM_IRQ = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_status_clr,
  input  logic               i_enable_we,
  input  logic [NUM_IRQ-1:0] i_enable_wdata,
  output logic [NUM_IRQ-1:0] o_status,
  output logic [NUM_IRQ-1:0] o_enable,
  output logic               o_irq
);

  logic [NUM_IRQ-1:0] prev_irq_q, prev_irq_d;
  logic [NUM_IRQ-1:0] status_q, status_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic               irq_q, irq_d;
  logic [NUM_IRQ-1:0] rise;

  always_comb begin
    rise       = i_irq & ~prev_irq_q;
    prev_irq_d = i_irq;
    // A new edge in the same cycle as a clear keeps the bit set.
    status_d   = (status_q & ~i_status_clr) | rise;
    enable_d   = i_enable_we ? i_enable_wdata : enable_q;
    irq_d      = |(status_q & enable_q);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      prev_irq_q <= '0;
      status_q   <= '0;
      enable_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_irq_q <= prev_irq_d;
      status_q   <= status_d;
      enable_q   <= enable_d;
      irq_q      <= irq_d;
    end
  end

  assign o_status = status_q;
  assign o_enable = enable_q;
  assign o_irq    = irq_q;

endmodule

// File: rtl/sysreg_bank.sv
// CPU-visible system register bank: board control, LEDs, 64-bit cycle counter with
// coherent LO/HI reads, scratch registers and interrupt capture behind a req/ready bus.
module sysreg_bank
  import sysreg_pkg::*;
#(
  parameter int FREQUENCY   = 100000000,
  parameter int DEVICEID    = 0,
  parameter int LED_WIDTH   = 8,
  parameter int NUM_IRQ     = 4,
  parameter int NUM_SCRATCH = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_request,
  input  logic                 i_rw,
  input  logic [3:0]           i_address,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_wmask,
  output logic [31:0]          o_rdata,
  output logic                 o_ready,
  input  logic                 i_boot_mode_switch,
  input  logic [NUM_IRQ-1:0]   i_irq,
  output logic [LED_WIDTH-1:0] o_leds,
  output logic                 o_sil9024_reset,
  output logic                 o_irq
);

  sysreg_state_t        state_q, state_d;
  logic                 boot_mode_q, boot_mode_d;
  logic                 sil_reset_q, sil_reset_d;
  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic [7:0][31:0]     scratch_q, scratch_d;
  logic [63:0]          cycle_q, cycle_d;
  logic [31:0]          shadow_q, shadow_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [31:0]          bmask;
  logic                 acc, wr, rd;
  logic [2:0]           scr_idx;
  logic                 scr_hit;
  logic [31:0]          rd_word;
  logic [NUM_IRQ-1:0]   status_clr;
  logic                 enable_we;
  logic [NUM_IRQ-1:0]   enable_wdata;
  logic [NUM_IRQ-1:0]   irq_status;
  logic [NUM_IRQ-1:0]   irq_enable;

  // An access is taken only from IDLE, so each request is serviced once.
  always_comb begin
    bmask   = byte_mask(i_wmask);
    acc     = (state_q == IDLE) && i_request;
    wr      = acc && i_rw;
    rd      = acc && !i_rw;
    scr_idx = i_address[2:0];
    scr_hit = (i_address >= ADDR_SCRATCH0) && (int'(scr_idx) < NUM_SCRATCH);
  end

  always_comb begin
    rd_word = '0;
    case (i_address)
      ADDR_CTRL: begin
        rd_word[CTRL_BOOT_MODE]     = boot_mode_q;
        rd_word[CTRL_SIL9024_RESET] = sil_reset_q;
      end
      ADDR_LEDS:       rd_word = 32'(leds_q);
      ADDR_FREQ:       rd_word = 32'(FREQUENCY);
      ADDR_DEVID:      rd_word = 32'(DEVICEID);
      ADDR_CYCLE_LO:   rd_word = cycle_q[31:0];
      ADDR_CYCLE_HI:   rd_word = shadow_q;
      ADDR_IRQ_STATUS: rd_word = 32'(irq_status);
      ADDR_IRQ_ENABLE: rd_word = 32'(irq_enable);
      default:         rd_word = scr_hit ? scratch_q[scr_idx] : 32'h0;
    endcase
  end

  always_comb begin
    boot_mode_d  = boot_mode_q;
    sil_reset_d  = sil_reset_q;
    leds_d       = leds_q;
    scratch_d    = scratch_q;
    status_clr   = '0;
    enable_we    = 1'b0;
    enable_wdata = (irq_enable & ~bmask[NUM_IRQ-1:0]) | (i_wdata[NUM_IRQ-1:0] & bmask[NUM_IRQ-1:0]);
    if (wr) begin
      case (i_address)
        ADDR_CTRL: begin
          if (bmask[0]) begin
            boot_mode_d = i_wdata[CTRL_BOOT_MODE];
            sil_reset_d = i_wdata[CTRL_SIL9024_RESET];
          end
        end
        ADDR_LEDS:
          leds_d = (leds_q & ~bmask[LED_WIDTH-1:0]) | (i_wdata[LED_WIDTH-1:0] & bmask[LED_WIDTH-1:0]);
        ADDR_IRQ_STATUS: status_clr = i_wdata[NUM_IRQ-1:0] & bmask[NUM_IRQ-1:0];
        ADDR_IRQ_ENABLE: enable_we  = 1'b1;
        default: begin
          if (scr_hit)
            scratch_d[scr_idx] = (scratch_q[scr_idx] & ~bmask) | (i_wdata & bmask);
        end
      endcase
    end
  end

  // Reading LO freezes the high word so a following HI read is coherent.
  always_comb begin
    cycle_d  = cycle_q + 64'd1;
    shadow_d = shadow_q;
    if (rd && (i_address == ADDR_CYCLE_LO))
      shadow_d = cycle_q[63:32];
    rdata_d = rdata_q;
    if (acc)
      rdata_d = i_rw ? 32'h0 : rd_word;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_request) state_d = ACK;
      ACK:     state_d = RELEASE;
      RELEASE: if (!i_request) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      boot_mode_q <= i_boot_mode_switch;
      sil_reset_q <= 1'b0;
      leds_q      <= '0;
      scratch_q   <= '0;
      cycle_q     <= '0;
      shadow_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      boot_mode_q <= boot_mode_d;
      sil_reset_q <= sil_reset_d;
      leds_q      <= leds_d;
      scratch_q   <= scratch_d;
      cycle_q     <= cycle_d;
      shadow_q    <= shadow_d;
      rdata_q     <= rdata_d;
    end
  end

  sysreg_irq_capture #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_irq         (i_irq),
    .i_status_clr  (status_clr),
    .i_enable_we   (enable_we),
    .i_enable_wdata(enable_wdata),
    .o_status      (irq_status),
    .o_enable      (irq_enable),
    .o_irq         (o_irq)
  );

  assign o_ready         = (state_q == ACK);
  assign o_rdata         = rdata_q;
  assign o_leds          = leds_q;
  assign o_sil9024_reset = sil_reset_q;

endmodule

// File: tb/tb_sysreg_bank.sv
// Directed bench for sysreg_bank: a vector table of bus accesses plus hand-written
// sequences for handshake, counter wrap, interrupt capture and mid-access reset.
module tb_sysreg_bank;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_request = 1'b0;
  logic        i_rw = 1'b0;
  logic [3:0]  i_address = '0;
  logic [31:0] i_wdata = '0;
  logic [3:0]  i_wmask = '0;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        i_boot_mode_switch = 1'b1;
  logic [3:0]  i_irq = '0;
  logic [7:0]  o_leds;
  logic        o_sil9024_reset;
  logic        o_irq;

  int checks = 0;
  int errors = 0;

  sysreg_bank dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_request         (i_request),
    .i_rw              (i_rw),
    .i_address         (i_address),
    .i_wdata           (i_wdata),
    .i_wmask           (i_wmask),
    .o_rdata           (o_rdata),
    .o_ready           (o_ready),
    .i_boot_mode_switch(i_boot_mode_switch),
    .i_irq             (i_irq),
    .o_leds            (o_leds),
    .o_sil9024_reset   (o_sil9024_reset),
    .o_irq             (o_irq)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic        rw;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic rw, input logic [3:0] a, input logic [31:0] wd,
                     input logic [3:0] wm, input logic [31:0] exp, input string name);
    vec_t v;
    v.rw = rw; v.addr = a; v.wdata = wd; v.wmask = wm; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic bus(input logic rw, input logic [3:0] a, input logic [31:0] wd,
                     input logic [3:0] wm, output logic [31:0] rd);
    bit got;
    @(negedge i_clock);
    i_request = 1'b1; i_rw = rw; i_address = a; i_wdata = wd; i_wmask = wm;
    got = 1'b0;
    rd  = '0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge i_clock); #1;
      if (o_ready) begin
        got = 1'b1;
        rd  = o_rdata;
      end
    end
    i_request = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL bus_timeout addr=%0d actual=no_ready required=ready", a);
    end
    repeat (2) @(posedge i_clock);
  endtask

  logic [31:0] rdv;
  int          rdy_cnt;

  initial begin
    // Table: starts right after reset with boot switch high.
    add(0, 4'd0,  32'h0,        4'hF, 32'h0000_0001, "ctrl_boot");
    add(0, 4'd2,  32'h0,        4'hF, 32'h05F5_E100, "freq");
    add(0, 4'd3,  32'h0,        4'hF, 32'h0000_0000, "devid");
    add(0, 4'd5,  32'h0,        4'hF, 32'h0000_0000, "hi_no_lo");
    add(1, 4'd1,  32'hDEADBEEF, 4'h1, 32'h0000_0000, "wr_leds_rdata");
    add(0, 4'd1,  32'h0,        4'hF, 32'h0000_00EF, "leds_rb");
    add(1, 4'd2,  32'hFFFFFFFF, 4'hF, 32'h0000_0000, "wr_freq_rdata");
    add(0, 4'd2,  32'h0,        4'hF, 32'h05F5_E100, "freq_unchanged");
    add(0, 4'd15, 32'h0,        4'hF, 32'h0000_0000, "unmapped15");
    add(1, 4'd8,  32'h12345678, 4'h5, 32'h0000_0000, "wr_scr0");
    add(0, 4'd8,  32'h0,        4'hF, 32'h0034_0078, "scr0_bytes");
    add(1, 4'd11, 32'hAABBCCDD, 4'hF, 32'h0000_0000, "wr_scr3");
    add(0, 4'd11, 32'h0,        4'hF, 32'hAABB_CCDD, "scr3_rb");
    add(1, 4'd12, 32'hFFFFFFFF, 4'hF, 32'h0000_0000, "wr_scr_oob");
    add(0, 4'd12, 32'h0,        4'hF, 32'h0000_0000, "scr_oob_rb");
    add(1, 4'd0,  32'h00000002, 4'h1, 32'h0000_0000, "wr_ctrl");
    add(0, 4'd0,  32'h0,        4'hF, 32'h0000_0002, "ctrl_rb");
    add(1, 4'd7,  32'hFFFFFFFF, 4'hF, 32'h0000_0000, "wr_en_all");
    add(0, 4'd7,  32'h0,        4'hF, 32'h0000_000F, "en_width");
    add(1, 4'd7,  32'h00000001, 4'hF, 32'h0000_0000, "wr_en0");
    add(0, 4'd6,  32'h0,        4'hF, 32'h0000_0000, "status_idle");

    repeat (3) @(posedge i_clock);
    #1;
    chk("rst_ready", 32'(o_ready), 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_leds",  32'(o_leds), 32'h0);
    chk("rst_sil",   32'(o_sil9024_reset), 32'h0);
    chk("rst_irq",   32'(o_irq), 32'h0);
    @(negedge i_clock);
    i_reset = 1'b0;

    foreach (vecs[i]) begin
      bus(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rdv);
      chk(vecs[i].name, rdv, vecs[i].exp);
    end
    chk("leds_out", 32'(o_leds), 32'h0000_00EF);
    chk("sil_out",  32'(o_sil9024_reset), 32'h1);

    // Request held 5 cycles: exactly one acknowledge.
    @(negedge i_clock);
    i_request = 1'b1; i_rw = 1'b0; i_address = 4'd1;
    rdy_cnt = 0;
    for (int n = 0; n < 5; n++) begin
      @(posedge i_clock); #1;
      if (o_ready) rdy_cnt++;
    end
    i_request = 1'b0;
    repeat (2) @(posedge i_clock);
    chk("ready_once", 32'(rdy_cnt), 32'h1);

    // Counter wrap of the low word; HI returns the shadow taken at the LO read.
    @(negedge i_clock);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    i_request = 1'b1; i_rw = 1'b0; i_address = 4'd4;
    @(posedge i_clock); #1;
    chk("lo_ready", 32'(o_ready), 32'h1);
    chk("lo_wrap",  o_rdata, 32'hFFFF_FFFF);
    i_request = 1'b0;
    @(negedge i_clock);
    release dut.cycle_q;
    repeat (8) @(posedge i_clock);
    bus(0, 4'd5, 32'h0, 4'hF, rdv);
    chk("hi_shadow", rdv, 32'h0);
    chk("live_hi", dut.cycle_q[63:32], 32'h1);
    bus(0, 4'd4, 32'h0, 4'hF, rdv);
    bus(0, 4'd5, 32'h0, 4'hF, rdv);
    chk("hi_coherent", rdv, 32'h1);

    // Interrupt: edge sets status, o_irq one cycle later.
    @(negedge i_clock);
    i_irq = 4'b0001;
    @(posedge i_clock); #1;
    chk("irq_lag", 32'(o_irq), 32'h0);
    @(posedge i_clock); #1;
    chk("irq_set", 32'(o_irq), 32'h1);
    i_irq = 4'b0000;
    bus(0, 4'd6, 32'h0, 4'hF, rdv);
    chk("status_set", rdv, 32'h1);
    bus(1, 4'd6, 32'h1, 4'hF, rdv);
    chk("irq_cleared", 32'(o_irq), 32'h0);
    bus(0, 4'd6, 32'h0, 4'hF, rdv);
    chk("status_w1c", rdv, 32'h0);
    // Re-arm, then clear in the same cycle as a new edge.
    @(negedge i_clock); i_irq = 4'b0001;
    @(negedge i_clock); i_irq = 4'b0000;
    @(negedge i_clock); i_irq = 4'b0001;
    i_request = 1'b1; i_rw = 1'b1; i_address = 4'd6; i_wdata = 32'h1; i_wmask = 4'hF;
    @(posedge i_clock); #1;
    chk("setwin_ready", 32'(o_ready), 32'h1);
    i_request = 1'b0;
    @(negedge i_clock); i_irq = 4'b0000;
    repeat (2) @(posedge i_clock);
    bus(0, 4'd6, 32'h0, 4'hF, rdv);
    chk("set_wins", rdv, 32'h1);
    bus(1, 4'd6, 32'h0, 4'hF, rdv);
    bus(0, 4'd6, 32'h0, 4'hF, rdv);
    chk("w0_noeffect", rdv, 32'h1);
    bus(1, 4'd6, 32'hF, 4'hF, rdv);
    // Masked source: status latches but o_irq stays low.
    @(negedge i_clock); i_irq = 4'b0010;
    repeat (3) @(posedge i_clock); #1;
    chk("masked_irq", 32'(o_irq), 32'h0);
    i_irq = 4'b0000;
    bus(0, 4'd6, 32'h0, 4'hF, rdv);
    chk("masked_status", rdv, 32'h2);

    // Reset during ACK.
    bus(1, 4'd1, 32'h55, 4'hF, rdv);
    bus(1, 4'd9, 32'h77, 4'hF, rdv);
    chk("pre_rst_leds", 32'(o_leds), 32'h55);
    @(negedge i_clock);
    i_request = 1'b1; i_rw = 1'b0; i_address = 4'd9;
    @(posedge i_clock); #1;
    chk("ack_before_rst", 32'(o_ready), 32'h1);
    @(negedge i_clock);
    i_reset = 1'b1; i_request = 1'b0; i_boot_mode_switch = 1'b0; i_irq = 4'b0100;
    @(posedge i_clock); #1;
    chk("rst_drop_ready", 32'(o_ready), 32'h0);
    chk("rst_leds_clr",   32'(o_leds), 32'h0);
    chk("rst_irq_clr",    32'(o_irq), 32'h0);
    @(negedge i_clock);
    i_reset = 1'b0;
    bus(0, 4'd9, 32'h0, 4'hF, rdv);
    chk("rst_scratch", rdv, 32'h0);
    bus(0, 4'd0, 32'h0, 4'hF, rdv);
    chk("rst_ctrl", rdv, 32'h0);
    bus(0, 4'd6, 32'h0, 4'hF, rdv);
    chk("high_at_release", rdv, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
